// File: rtl/lzd_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lzd_norm_pipe
// Purpose  : Three-stage valid/ready pipeline that takes a WIDTH-bit word
//            (optionally two's complement), forms its sign and magnitude,
//            counts the magnitude's leading zeros and left-justifies the
//            magnitude so its MSB is 1. Feeds the exponent/mantissa packer.
// Ports    : clk        - clock, all state updates on the rising edge
//            rst        - synchronous active-high reset
//            in_valid   - input word present
//            in_ready   - block accepts a word this cycle
//            in_data    - input word [WIDTH-1:0]
//            out_valid  - result present
//            out_ready  - downstream accepts the result
//            out_sign   - sign of the input (0 when SIGNED=0)
//            out_lzd    - leading zeros of the magnitude, 0..WIDTH [CW-1:0]
//            out_zero   - magnitude is zero
//            out_norm   - magnitude << out_lzd, 0 when out_zero
// Revision : 1.0 - initial release
// ============================================================================
module lzd_norm_pipe #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [CW-1:0]    out_lzd,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_norm
);

    // Count tree geometry: 4-bit leaves, halving levels up to the root.
    localparam int c_NLEAF = WIDTH / 4;
    localparam int c_NLVL  = $clog2(c_NLEAF);
    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    generate
        if ((WIDTH < 8) || (WIDTH > 64) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
            $error("lzd_norm_pipe: WIDTH must be a power of 2 in 8..64");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake. Each stage loads when it is empty or its successor loads.
    // in_ready is therefore a combinational function of out_ready through
    // three stages of valid bits: downstream logic must budget for the
    // out_ready -> in_ready path when closing timing.
    // ------------------------------------------------------------------
    logic w_ld1;
    logic w_ld2;
    logic w_ld3;

    logic             r_v1;
    logic             r_sign1;
    logic [WIDTH-1:0] r_mag1;

    logic             r_v2;
    logic             r_sign2;
    logic [WIDTH-1:0] r_mag2;
    logic [CW-1:0]    r_lzd2;
    logic             r_zero2;

    logic             r_v3;
    logic             r_sign3;
    logic [CW-1:0]    r_lzd3;
    logic             r_zero3;
    logic [WIDTH-1:0] r_norm3;

    assign w_ld3    = !r_v3 || out_ready;
    assign w_ld2    = !r_v2 || w_ld3;
    assign w_ld1    = !r_v1 || w_ld2;
    assign in_ready = w_ld1;

    // ------------------------------------------------------------------
    // S1: sign / magnitude. The most negative input negates to itself,
    // which read as unsigned is exactly 2^(WIDTH-1) -- the right magnitude.
    // ------------------------------------------------------------------
    logic             w_in_sign;
    logic [WIDTH-1:0] w_in_mag;

    assign w_in_sign = (SIGNED != 1'b0) ? in_data[WIDTH-1] : 1'b0;
    assign w_in_mag  = w_in_sign ? (~in_data + c_ONE) : in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_sign1 <= 1'b0;
            r_mag1  <= '0;
        end else if (w_ld1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_sign1 <= w_in_sign;
                r_mag1  <= w_in_mag;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: leading-zero count. Leaves count within 4-bit nibbles; each
    // level merges pairs (2j+1 is the more significant half): if the upper
    // half is all zero the count is half-size plus the lower count,
    // otherwise the upper count. Entries are rewritten in place from low
    // index upward, so every read precedes the overwrite of that slot.
    // An all-zero word naturally yields WIDTH.
    // ------------------------------------------------------------------
    logic [CW-1:0] w_cnt [c_NLEAF];
    logic          w_z   [c_NLEAF];

    always_comb begin
        for (int i = 0; i < c_NLEAF; i++) begin
            w_z[i] = (r_mag1[4*i +: 4] == 4'b0000);
            casez (r_mag1[4*i +: 4])
                4'b1???: w_cnt[i] = CW'(0);
                4'b01??: w_cnt[i] = CW'(1);
                4'b001?: w_cnt[i] = CW'(2);
                4'b0001: w_cnt[i] = CW'(3);
                default: w_cnt[i] = CW'(4);
            endcase
        end
        for (int l = 1; l <= c_NLVL; l++) begin
            for (int j = 0; j < c_NLEAF / 2; j++) begin
                if (j < (c_NLEAF >> l)) begin
                    if (w_z[2*j+1]) begin
                        w_cnt[j] = CW'(4 << (l - 1)) + w_cnt[2*j];
                    end else begin
                        w_cnt[j] = w_cnt[2*j+1];
                    end
                    w_z[j] = w_z[2*j+1] & w_z[2*j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2    <= 1'b0;
            r_sign2 <= 1'b0;
            r_mag2  <= '0;
            r_lzd2  <= '0;
            r_zero2 <= 1'b0;
        end else if (w_ld2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_sign2 <= r_sign1;
                r_mag2  <= r_mag1;
                r_lzd2  <= w_cnt[0];
                r_zero2 <= w_z[0];
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: normalise. A shift by WIDTH (zero input) leaves all zeros.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_norm;

    assign w_norm = r_mag2 << r_lzd2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v3    <= 1'b0;
            r_sign3 <= 1'b0;
            r_lzd3  <= '0;
            r_zero3 <= 1'b0;
            r_norm3 <= '0;
        end else if (w_ld3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_sign3 <= r_sign2;
                r_lzd3  <= r_lzd2;
                r_zero3 <= r_zero2;
                r_norm3 <= w_norm;
            end
        end
    end

    assign out_valid = r_v3;
    assign out_sign  = r_sign3;
    assign out_lzd   = r_lzd3;
    assign out_zero  = r_zero3;
    assign out_norm  = r_norm3;

endmodule
`default_nettype wire
